// File: rtl/wb_memtest.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : wb_memtest
// Brief    : Wishbone initiator that fills a window with a 32-bit Galois LFSR
//            pattern, reads it back and reports the first mismatch and an
//            error count. Optional watchdog: define WB_MEMTEST_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module wb_memtest #(
    parameter int CNT_WIDTH = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [31:0]          base_adr,
    input  logic [CNT_WIDTH-1:0] words,
    input  logic [31:0]          seed,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 timeout_err,
    output logic [CNT_WIDTH-1:0] err_cnt,
    output logic [31:0]          err_adr,
    output logic [31:0]          err_exp,
    output logic [31:0]          err_got,
    output logic                 wb_cyc_o,
    output logic                 wb_stb_o,
    output logic                 wb_we_o,
    output logic [31:0]          wb_adr_o,
    output logic [3:0]           wb_sel_o,
    output logic [31:0]          wb_dat_o,
    input  logic [31:0]          wb_dat_i,
    input  logic                 wb_ack_i
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR   = 3'd1,
        S_WGAP = 3'd2,
        S_RD   = 3'd3,
        S_RGAP = 3'd4,
        S_FIN  = 3'd5
    } state_t;

    localparam logic [31:0] c_poly = 32'h0040_0007;

    state_t                 r_state;
    state_t                 w_next;
    logic [31:0]            r_base;
    logic [CNT_WIDTH-1:0]   r_words;
    logic [CNT_WIDTH-1:0]   r_idx;
    logic [31:0]            r_seed;
    logic [31:0]            r_lfsr;
    logic [31:0]            r_adr;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_pass;
    logic                   r_tmo_err;
    logic [CNT_WIDTH-1:0]   r_err_cnt;
    logic [31:0]            r_err_adr;
    logic [31:0]            r_err_exp;
    logic [31:0]            r_err_got;
    logic                   w_bus;
    logic                   w_abort;
    logic                   w_last;
    logic [31:0]            w_seed;
    logic [31:0]            w_lfsr_nxt;

    assign w_bus      = (r_state == S_WR) || (r_state == S_RD);
    assign w_last     = (r_idx == r_words);
    assign w_seed     = (seed == 32'd0) ? 32'd1 : seed;
    assign w_lfsr_nxt = {r_lfsr[30:0], 1'b0} ^ (r_lfsr[31] ? c_poly : 32'd0);

`ifdef WB_MEMTEST_TIMEOUT_EN
    logic [15:0] r_wdog;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wdog <= 16'd0;
        end else if (!w_bus || wb_ack_i) begin
            r_wdog <= 16'd0;
        end else begin
            r_wdog <= r_wdog + 16'd1;
        end
    end

    // Abort on the edge that would complete the TIMEOUT-th un-acked strobe cycle.
    assign w_abort = w_bus && !wb_ack_i && (r_wdog == 16'(TIMEOUT - 1));
`else
    assign w_abort = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start) w_next = (words == '0) ? S_FIN : S_WR;
            S_WR: begin
                if (wb_ack_i)     w_next = S_WGAP;
                else if (w_abort) w_next = S_FIN;
            end
            S_WGAP: w_next = w_last ? S_RD : S_WR;
            S_RD: begin
                if (wb_ack_i)     w_next = S_RGAP;
                else if (w_abort) w_next = S_FIN;
            end
            S_RGAP: w_next = w_last ? S_FIN : S_RD;
            S_FIN:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_base    <= 32'd0;
            r_words   <= '0;
            r_idx     <= '0;
            r_seed    <= 32'd0;
            r_lfsr    <= 32'd0;
            r_adr     <= 32'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_tmo_err <= 1'b0;
            r_err_cnt <= '0;
            r_err_adr <= 32'd0;
            r_err_exp <= 32'd0;
            r_err_got <= 32'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_base    <= base_adr & 32'hFFFF_FFFC;
                        r_adr     <= base_adr & 32'hFFFF_FFFC;
                        r_words   <= words;
                        r_seed    <= w_seed;
                        r_lfsr    <= w_seed;
                        r_idx     <= '0;
                        r_err_cnt <= '0;
                        r_pass    <= 1'b0;
                        r_tmo_err <= 1'b0;
                        r_busy    <= 1'b1;
                    end
                end
                S_WR: begin
                    if (wb_ack_i) begin
                        r_lfsr <= w_lfsr_nxt;
                        r_idx  <= r_idx + 1'b1;
                        r_adr  <= r_adr + 32'd4;
                    end else if (w_abort) begin
                        r_tmo_err <= 1'b1;
                    end
                end
                S_WGAP: begin
                    if (w_last) begin
                        r_lfsr <= r_seed;
                        r_idx  <= '0;
                        r_adr  <= r_base;
                    end
                end
                S_RD: begin
                    if (wb_ack_i) begin
                        if (wb_dat_i != r_lfsr) begin
                            // A zero count means this is the run's first mismatch.
                            if (r_err_cnt == '0) begin
                                r_err_adr <= r_adr;
                                r_err_exp <= r_lfsr;
                                r_err_got <= wb_dat_i;
                            end
                            if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
                        end
                        r_lfsr <= w_lfsr_nxt;
                        r_idx  <= r_idx + 1'b1;
                        r_adr  <= r_adr + 32'd4;
                    end else if (w_abort) begin
                        r_tmo_err <= 1'b1;
                    end
                end
                S_FIN: begin
                    r_done <= 1'b1;
                    r_pass <= (r_err_cnt == '0) && !r_tmo_err;
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign pass        = r_pass;
    assign timeout_err = r_tmo_err;
    assign err_cnt     = r_err_cnt;
    assign err_adr     = r_err_adr;
    assign err_exp     = r_err_exp;
    assign err_got     = r_err_got;
    assign wb_cyc_o    = w_bus;
    assign wb_stb_o    = w_bus;
    assign wb_we_o     = (r_state == S_WR);
    assign wb_adr_o    = r_adr;
    assign wb_sel_o    = w_bus ? 4'hF : 4'h0;
    assign wb_dat_o    = r_lfsr;

endmodule
`default_nettype wire

// File: tb/tb_wb_memtest.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_wb_memtest
// Brief    : Self-checking bench for wb_memtest with a 1-cycle-ack memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_memtest;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_adr = 32'd0;
    logic [15:0] words = 16'd0;
    logic [31:0] seed = 32'd0;
    logic        busy, done, pass, timeout_err;
    logic [15:0] err_cnt;
    logic [31:0] err_adr, err_exp, err_got;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_i = 32'd0;
    logic        wb_ack_i = 1'b0;

    wb_memtest #(.CNT_WIDTH(16), .TIMEOUT(15)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_adr(base_adr),
        .words(words), .seed(seed), .busy(busy), .done(done), .pass(pass),
        .timeout_err(timeout_err), .err_cnt(err_cnt), .err_adr(err_adr),
        .err_exp(err_exp), .err_got(err_got), .wb_cyc_o(wb_cyc_o),
        .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
        .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i)
    );

    always #5 clk = ~clk;

    // Memory model: acks one cycle after the strobe, optional read corruption.
    typedef struct { logic [31:0] adr; logic [31:0] dat; } wr_t;
    wr_t         wlog[$];
    logic [31:0] mem[16];
    logic [31:0] flip_adr = 32'hDEAD_0000;
    logic [31:0] flip_mask = 32'd0;
    logic        noack = 1'b0;

    always @(posedge clk) begin
        if (noack) wb_ack_i <= 1'b0;
        else       wb_ack_i <= wb_cyc_o && wb_stb_o && !wb_ack_i;
        if (wb_cyc_o && wb_stb_o && !wb_ack_i) begin
            if (wb_we_o) begin
                mem[wb_adr_o[5:2]] <= wb_dat_o;
                wlog.push_back('{wb_adr_o, wb_dat_o});
            end
            wb_dat_i <= mem[wb_adr_o[5:2]] ^ ((wb_adr_o == flip_adr) ? flip_mask : 32'd0);
        end
    end

    int done_cnt = 0, cyc_cnt = 0, stb_cnt = 0, sel_bad = 0;
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (wb_cyc_o) cyc_cnt++;
        if (wb_stb_o) stb_cnt++;
        if (wb_stb_o && wb_sel_o != 4'hF) sel_bad++;
    end

    int n_pass = 0, n_total = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got 0x%08h required 0x%08h", name, got, exp);
        else n_pass++;
    endtask

    function automatic logic [31:0] lfsr_nx(input logic [31:0] p);
        return {p[30:0], 1'b0} ^ (p[31] ? 32'h0040_0007 : 32'h0);
    endfunction

    // Runs one test; returns cycles from start to done and done pulses seen.
    task automatic run(input logic [15:0] w, input logic [31:0] b, input logic [31:0] s,
                       input logic [31:0] fa, input logic [31:0] fm,
                       output int cyc, output int dn);
        int d0;
        d0 = done_cnt;
        flip_adr = fa; flip_mask = fm;
        words = w; base_adr = b; seed = s; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cyc = 1;
        while (!done && cyc < 500) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!done) chk("done_seen", 32'd0, 32'd1);
        repeat (3) @(posedge clk);
        #1 dn = done_cnt - d0;
    endtask

    typedef struct {
        logic [15:0] w;
        logic [31:0] base, sd, fa, fm;
        logic [15:0] e_cnt;
        logic        e_pass;
        logic [31:0] e_adr, e_exp, e_got;
        int          e_cyc;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int cyc, dn, ls, c0, s0;
        logic [31:0] p, a;

        vecs[0] = '{16'd4, 32'h100, 32'd1, 32'hDEAD_0000, 32'd0, 16'd0, 1'b1,
                    32'h0, 32'h0, 32'h0, 26};
        vecs[1] = '{16'd4, 32'h100, 32'd1, 32'h108, 32'd1, 16'd1, 1'b0,
                    32'h108, 32'h4, 32'h5, 26};
        vecs[2] = '{16'd0, 32'h100, 32'd1, 32'hDEAD_0000, 32'd0, 16'd0, 1'b1,
                    32'h108, 32'h4, 32'h5, 2};
        vecs[3] = '{16'd3, 32'h103, 32'd0, 32'h108, 32'd2, 16'd1, 1'b0,
                    32'h108, 32'h4, 32'h6, 20};
        vecs[4] = '{16'd2, 32'hFFFF_FFFC, 32'd1, 32'hDEAD_0000, 32'd0, 16'd0, 1'b1,
                    32'h108, 32'h4, 32'h6, 14};
        vecs[5] = '{16'd2, 32'h0, 32'h8000_0000, 32'h4, 32'd1, 16'd1, 1'b0,
                    32'h4, 32'h0040_0007, 32'h0040_0006, 14};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_pass", {31'd0, pass}, 32'd0);
        chk("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
        chk("rst_sel", {28'd0, wb_sel_o}, 32'd0);
        chk("rst_errs", {16'd0, err_cnt} | err_adr | err_exp | err_got, 32'd0);
        chk("rst_bus", wb_adr_o | wb_dat_o, 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 6; v++) begin
            ls = wlog.size(); c0 = cyc_cnt;
            run(vecs[v].w, vecs[v].base, vecs[v].sd, vecs[v].fa, vecs[v].fm, cyc, dn);
            chk($sformatf("v%0d_cycles", v), 32'(cyc), 32'(vecs[v].e_cyc));
            chk($sformatf("v%0d_dones", v), 32'(dn), 32'd1);
            chk($sformatf("v%0d_pass", v), {31'd0, pass}, {31'd0, vecs[v].e_pass});
            chk($sformatf("v%0d_busy", v), {31'd0, busy}, 32'd0);
            chk($sformatf("v%0d_tmo", v), {31'd0, timeout_err}, 32'd0);
            chk($sformatf("v%0d_err_cnt", v), {16'd0, err_cnt}, {16'd0, vecs[v].e_cnt});
            chk($sformatf("v%0d_err_adr", v), err_adr, vecs[v].e_adr);
            chk($sformatf("v%0d_err_exp", v), err_exp, vecs[v].e_exp);
            chk($sformatf("v%0d_err_got", v), err_got, vecs[v].e_got);
            chk($sformatf("v%0d_cyc_any", v), {31'd0, (cyc_cnt != c0)},
                {31'd0, (vecs[v].w != 16'd0)});
            chk($sformatf("v%0d_wr_count", v), 32'(wlog.size() - ls), {16'd0, vecs[v].w});
            p = (vecs[v].sd == 32'd0) ? 32'd1 : vecs[v].sd;
            a = vecs[v].base & 32'hFFFF_FFFC;
            for (int i = 0; i < int'(vecs[v].w) && ls + i < wlog.size(); i++) begin
                chk($sformatf("v%0d_wr%0d_adr", v, i), wlog[ls + i].adr, a);
                chk($sformatf("v%0d_wr%0d_dat", v, i), wlog[ls + i].dat, p);
                p = lfsr_nx(p);
                a = a + 32'd4;
            end
        end
        chk("sel_always_f", 32'(sel_bad), 32'd0);

        // Reset asserted while word 2 is on the bus.
        words = 16'd4; base_adr = 32'h100; seed = 32'd1; flip_adr = 32'hDEAD_0000;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        c0 = 0;
        while (!(wb_stb_o && wb_adr_o == 32'h108) && c0 < 50) begin
            @(posedge clk); #1;
            c0++;
        end
        chk("mid_word2_seen", {31'd0, (wb_stb_o && wb_adr_o == 32'h108)}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
        chk("mid_rst_stb", {31'd0, wb_stb_o}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_err_adr", err_adr, 32'd0);
        @(posedge clk); #1 reset_n = 1'b1;
        ls = wlog.size();
        run(16'd1, 32'h100, 32'd1, 32'hDEAD_0000, 32'd0, cyc, dn);
        chk("post_rst_dones", 32'(dn), 32'd1);
        chk("post_rst_wr_count", 32'(wlog.size() - ls), 32'd1);
        if (wlog.size() > ls) chk("post_rst_first_dat", wlog[ls].dat, 32'd1);
        chk("post_rst_pass", {31'd0, pass}, 32'd1);

        // Seed 0 plus a second start while busy.
        ls = wlog.size(); dn = done_cnt;
        words = 16'd2; base_adr = 32'h200; seed = 32'd0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 start = 1'b1; seed = 32'd5; words = 16'd4;
        @(posedge clk); #1 start = 1'b0;
        c0 = 0;
        while (!done && c0 < 100) begin
            @(posedge clk); #1;
            c0++;
        end
        repeat (30) @(posedge clk);
        #1;
        chk("restart_dones", 32'(done_cnt - dn), 32'd1);
        chk("restart_wr_count", 32'(wlog.size() - ls), 32'd2);
        if (wlog.size() > ls + 1) begin
            chk("seed0_first_dat", wlog[ls].dat, 32'd1);
            chk("seed0_second_dat", wlog[ls + 1].dat, 32'd2);
        end
        chk("restart_busy", {31'd0, busy}, 32'd0);

`ifdef WB_MEMTEST_TIMEOUT_EN
        noack = 1'b1;
        s0 = stb_cnt;
        run(16'd2, 32'h100, 32'd1, 32'hDEAD_0000, 32'd0, cyc, dn);
        chk("wd_stb_cycles", 32'(stb_cnt - s0), 32'd15);
        chk("wd_cycles", 32'(cyc), 32'd17);
        chk("wd_dones", 32'(dn), 32'd1);
        chk("wd_tmo_err", {31'd0, timeout_err}, 32'd1);
        chk("wd_pass", {31'd0, pass}, 32'd0);
        noack = 1'b0;
`else
        s0 = stb_cnt;
        chk("stb_idle", 32'(stb_cnt - s0), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
